// File: rtl/memshare_vn_iblut_rank_loader.sv
// memshare_vn_iblut_rank_loader
// IB-LUT rank for one share group of LANES variable nodes. Each lane owns a
// lookup table (GP1 or GP2 depth chosen by GP2_MASK). A sequential loader
// streams new contents into every lane's table, and a registered lookup path
// turns C2V messages into V2C messages. Lookups are locked out while the
// tables are being reloaded.
//
// Optional build macro: IBLUT_OUT_REG_EN adds a second output register stage,
// giving a lookup latency of 2 cycles instead of 1.
module memshare_vn_iblut_rank_loader #(
    parameter int              LANES     = 4,
    parameter int              QUAN_SIZE = 4,
    parameter int              GP1_SEL_W = 1,
    parameter int              GP2_SEL_W = 2,
    parameter logic [LANES-1:0] GP2_MASK = 4'b1010
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         lut_in_valid_i,
    output logic                         lut_in_ready_o,
    input  logic [LANES*GP2_SEL_W-1:0]   col_sel_vec_i,
    input  logic [LANES*QUAN_SIZE-1:0]   c2v_msg_vec_i,
    output logic [LANES*QUAN_SIZE-1:0]   v2c_msg_vec_o,
    output logic                         v2c_valid_o,
    input  logic                         remap_start_i,
    input  logic [LANES*QUAN_SIZE-1:0]   remap_data_vec_i,
    input  logic                         remap_valid_i,
    output logic                         remap_ready_o,
    output logic                         remap_busy_o,
    output logic                         remap_done_o
);

    // The load counter walks the full GP2 address space as {sel, c2v}.
    localparam int CNT_W = GP2_SEL_W + QUAN_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [CNT_W-1:0]             load_cnt;
    logic                         lookup_accept;
    logic                         load_beat;
    logic                         load_last;
    logic                         pipe_pending;
    logic                         pipe_empty;
    logic                         rd_valid;
    logic [LANES*QUAN_SIZE-1:0]   rd_vec;
    logic                         unused_sel;

    // GP1 lanes never look at the upper select bits of their field.
    assign unused_sel = ^col_sel_vec_i;

    assign lookup_accept = lut_in_valid_i && lut_in_ready_o;
    assign load_beat     = (state == LOAD) && remap_valid_i;
    assign load_last     = load_beat && (load_cnt == {CNT_W{1'b1}});

    // State register; a reset anywhere (including mid-load) returns to IDLE.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a start request waits for in-flight lookups to leave.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (remap_start_i) begin
                    if (lookup_accept || pipe_pending) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (load_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        lut_in_ready_o = 1'b0;
        remap_ready_o  = 1'b0;
        remap_busy_o   = 1'b0;
        remap_done_o   = 1'b0;
        unique case (state)
            IDLE: begin
                lut_in_ready_o = !rst;
            end
            DRAIN: begin
                remap_busy_o = 1'b1;
            end
            LOAD: begin
                remap_ready_o = 1'b1;
                remap_busy_o  = 1'b1;
            end
            DONE: begin
                remap_busy_o = 1'b1;
                remap_done_o = 1'b1;
            end
            default: begin
                lut_in_ready_o = 1'b0;
            end
        endcase
    end

    // Load address counter; wraps to 0 after the final address is written.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            load_cnt <= '0;
        end else if (load_beat) begin
            load_cnt <= load_cnt + 1'b1;
        end
    end

    // First read stage valid flag, one cycle behind each accepted lookup.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= lookup_accept;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int SEL_W = GP2_MASK[i] ? GP2_SEL_W : GP1_SEL_W;
        localparam int AW    = SEL_W + QUAN_SIZE;

        logic [QUAN_SIZE-1:0] mem [2**AW];
        logic [AW-1:0]        rd_addr;
        logic [AW-1:0]        wr_addr;
        logic                 wr_en;
        logic [QUAN_SIZE-1:0] rd_data;

        assign rd_addr = {col_sel_vec_i[i*GP2_SEL_W +: SEL_W],
                          c2v_msg_vec_i[i*QUAN_SIZE +: QUAN_SIZE]};
        assign wr_addr = load_cnt[AW-1:0];

        // Shallow lanes only take beats whose extra select bits are zero.
        if (AW == CNT_W) begin : g_full
            assign wr_en = load_beat;
        end else begin : g_part
            assign wr_en = load_beat && (load_cnt[CNT_W-1:AW] == '0);
        end

        // Table write port driven by the loader stream.
        always_ff @(posedge sys_clk) begin
            if (wr_en) begin
                mem[wr_addr] <= remap_data_vec_i[i*QUAN_SIZE +: QUAN_SIZE];
            end
        end

        // Registered table read; holds its value between accepted lookups.
        always_ff @(posedge sys_clk or posedge rst) begin
            if (rst) begin
                rd_data <= '0;
            end else if (lookup_accept) begin
                rd_data <= mem[rd_addr];
            end
        end

        assign rd_vec[i*QUAN_SIZE +: QUAN_SIZE] = rd_data;
    end

`ifdef IBLUT_OUT_REG_EN
    logic                       out_valid;
    logic [LANES*QUAN_SIZE-1:0] out_data;

    // Extra output stage; captures each read result as it arrives.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= rd_valid;
            if (rd_valid) begin
                out_data <= rd_vec;
            end
        end
    end

    assign v2c_msg_vec_o = out_data;
    assign v2c_valid_o   = out_valid;
    assign pipe_pending  = rd_valid;
    assign pipe_empty    = !rd_valid && !out_valid;
`else
    assign v2c_msg_vec_o = rd_vec;
    assign v2c_valid_o   = rd_valid;
    assign pipe_pending  = 1'b0;
    assign pipe_empty    = 1'b1;
`endif

endmodule

// File: tb/tb_memshare_vn_iblut_rank_loader.sv
// Directed testbench for memshare_vn_iblut_rank_loader (default 4-lane config).
module tb_memshare_vn_iblut_rank_loader;

`ifdef IBLUT_OUT_REG_EN
    localparam int LAT       = 2;
    localparam int DRAIN_CYC = 3;
`else
    localparam int LAT       = 1;
    localparam int DRAIN_CYC = 1;
`endif

    logic        sys_clk;
    logic        rst;
    logic        lut_in_valid_i;
    logic        lut_in_ready_o;
    logic [7:0]  col_sel_vec_i;
    logic [15:0] c2v_msg_vec_i;
    logic [15:0] v2c_msg_vec_o;
    logic        v2c_valid_o;
    logic        remap_start_i;
    logic [15:0] remap_data_vec_i;
    logic        remap_valid_i;
    logic        remap_ready_o;
    logic        remap_busy_o;
    logic        remap_done_o;

    int checks;
    int failures;
    int beats;
    int cyc;
    int idx;
    logic v;

    logic [7:0]  reqSel [2];
    logic [15:0] reqC2v [2];
    logic [15:0] expMsg [2];

    memshare_vn_iblut_rank_loader dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .lut_in_valid_i   (lut_in_valid_i),
        .lut_in_ready_o   (lut_in_ready_o),
        .col_sel_vec_i    (col_sel_vec_i),
        .c2v_msg_vec_i    (c2v_msg_vec_i),
        .v2c_msg_vec_o    (v2c_msg_vec_o),
        .v2c_valid_o      (v2c_valid_o),
        .remap_start_i    (remap_start_i),
        .remap_data_vec_i (remap_data_vec_i),
        .remap_valid_i    (remap_valid_i),
        .remap_ready_o    (remap_ready_o),
        .remap_busy_o     (remap_busy_o),
        .remap_done_o     (remap_done_o)
    );

    // Free-running 10-unit clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic stepClock();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Load beat data: lane i gets (addr + i) mod 16.
    function automatic logic [15:0] loadData(input int addr);
        logic [15:0] d;
        for (int i = 0; i < 4; i++) begin
            d[i*4 +: 4] = 4'((addr + i) % 16);
        end
        return d;
    endfunction

    task automatic applyStimulus(input logic valid, input logic [7:0] sel, input logic [15:0] c2v);
        lut_in_valid_i = valid;
        col_sel_vec_i  = sel;
        c2v_msg_vec_i  = c2v;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Lookup vectors and hand-computed results after a full load.
        // Req0: lane0 {1,5}=21->5, lane1 {11,5}=53->6, lane2 {1,A}=26->C, lane3 {00,F}=15->2
        reqSel[0] = 8'h1F; reqC2v[0] = 16'hFA55; expMsg[0] = 16'h2C65;
        // Req1: lane0 {1,0}=16->0, lane1 {00,0}=0->1, lane2 {0,3}=3->5, lane3 {11,F}=63->2
        reqSel[1] = 8'hE1; reqC2v[1] = 16'hF300; expMsg[1] = 16'h2510;

        rst = 1'b1;
        remap_start_i = 1'b0;
        remap_valid_i = 1'b0;
        remap_data_vec_i = '0;
        applyStimulus(1'b0, 8'h00, 16'h0000);

        // Reset state.
        repeat (2) stepClock();
        checkOutput("rst_busy", remap_busy_o, 0);
        checkOutput("rst_done", remap_done_o, 0);
        checkOutput("rst_rready", remap_ready_o, 0);
        checkOutput("rst_v2c_valid", v2c_valid_o, 0);
        checkOutput("rst_v2c_msg", v2c_msg_vec_o, 0);
        checkOutput("rst_lut_ready", lut_in_ready_o, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_lut_ready", lut_in_ready_o, 1);

        // Partial load of 10 beats, with ignored lookups, then reset mid-load.
        remap_start_i = 1'b1;
        stepClock();
        remap_start_i = 1'b0;
        checkOutput("load_rready", remap_ready_o, 1);
        checkOutput("load_busy", remap_busy_o, 1);
        checkOutput("load_lut_ready", lut_in_ready_o, 0);
        for (int b = 0; b < 10; b++) begin
            remap_valid_i = 1'b1;
            remap_data_vec_i = 16'hFFFF;
            applyStimulus(1'b1, reqSel[0], reqC2v[0]);
            stepClock();
            checkOutput("partial_done", remap_done_o, 0);
            checkOutput("partial_v2c_valid", v2c_valid_o, 0);
        end
        remap_valid_i = 1'b0;
        applyStimulus(1'b0, 8'h00, 16'h0000);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", remap_busy_o, 0);
        checkOutput("midrst_rready", remap_ready_o, 0);
        checkOutput("midrst_done", remap_done_o, 0);
        checkOutput("midrst_v2c_valid", v2c_valid_o, 0);
        stepClock();
        rst = 1'b0;

        // Full load with random gaps; done must follow the 64th beat exactly.
        remap_start_i = 1'b1;
        stepClock();
        remap_start_i = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < 64 && cyc < 2000) begin
            v = ($urandom_range(0, 2) != 0);
            remap_valid_i = v;
            remap_data_vec_i = loadData(beats);
            stepClock();
            cyc++;
            if (v) beats++;
            if (beats < 64) checkOutput("full_no_early_done", remap_done_o, 0);
        end
        checkOutput("full_beats", beats, 64);
        remap_valid_i = 1'b0;
        checkOutput("done_pulse", remap_done_o, 1);
        checkOutput("done_busy", remap_busy_o, 1);
        checkOutput("done_rready", remap_ready_o, 0);
        checkOutput("done_lut_ready", lut_in_ready_o, 0);
        applyStimulus(1'b1, reqSel[0], reqC2v[0]);
        stepClock();
        applyStimulus(1'b0, reqSel[0], reqC2v[0]);
        checkOutput("after_done_pulse", remap_done_o, 0);
        checkOutput("after_done_busy", remap_busy_o, 0);
        checkOutput("after_done_lut_ready", lut_in_ready_o, 1);
        checkOutput("done_lookup_ignored", v2c_valid_o, 0);

        // Back-to-back lookups covering GP1 and GP2 lanes, then hold.
        for (int k = 0; k < LAT + 2; k++) begin
            if (k < 2) applyStimulus(1'b1, reqSel[k], reqC2v[k]);
            else applyStimulus(1'b0, 8'hAA, 16'h1234);
            stepClock();
            idx = k - (LAT - 1);
            if (idx == 0 || idx == 1) begin
                checkOutput("lookup_valid", v2c_valid_o, 1);
                checkOutput("lookup_msg", v2c_msg_vec_o, expMsg[idx]);
            end else if (idx >= 2) begin
                checkOutput("hold_valid", v2c_valid_o, 0);
                checkOutput("hold_msg", v2c_msg_vec_o, expMsg[1]);
            end else begin
                checkOutput("lookup_pipe_valid", v2c_valid_o, 0);
            end
        end

        // Start with a lookup accepted in the same cycle: DRAIN then LOAD.
        applyStimulus(1'b1, reqSel[0], reqC2v[0]);
        remap_start_i = 1'b1;
        for (int c = 1; c <= DRAIN_CYC; c++) begin
            stepClock();
            applyStimulus(1'b0, 8'h00, 16'h0000);
            remap_start_i = 1'b0;
            checkOutput("drain_lut_ready", lut_in_ready_o, 0);
            checkOutput("drain_rready", remap_ready_o, 0);
            checkOutput("drain_busy", remap_busy_o, 1);
            if (c == LAT) begin
                checkOutput("drain_v2c_valid", v2c_valid_o, 1);
                checkOutput("drain_v2c_msg", v2c_msg_vec_o, expMsg[0]);
            end
        end
        stepClock();
        checkOutput("drain_to_load", remap_ready_o, 1);

        // Reload same pattern; ignored start and lookup partway through.
        beats = 0;
        for (int b = 0; b < 5; b++) begin
            remap_valid_i = 1'b1;
            remap_data_vec_i = loadData(beats);
            stepClock();
            beats++;
        end
        remap_valid_i = 1'b0;
        remap_start_i = 1'b1;
        applyStimulus(1'b1, reqSel[1], reqC2v[1]);
        stepClock();
        remap_start_i = 1'b0;
        applyStimulus(1'b0, 8'h00, 16'h0000);
        checkOutput("ign_v2c_valid", v2c_valid_o, 0);
        checkOutput("ign_rready", remap_ready_o, 1);
        checkOutput("ign_lut_ready", lut_in_ready_o, 0);
        while (beats < 64) begin
            remap_valid_i = 1'b1;
            remap_data_vec_i = loadData(beats);
            stepClock();
            beats++;
            if (beats < 64) checkOutput("reload_no_early_done", remap_done_o, 0);
            checkOutput("reload_v2c_valid", v2c_valid_o, 0);
        end
        remap_valid_i = 1'b0;
        checkOutput("reload_done", remap_done_o, 1);
        stepClock();
        checkOutput("reload_idle_ready", lut_in_ready_o, 1);

        // Final lookup after reload.
        applyStimulus(1'b1, reqSel[1], reqC2v[1]);
        stepClock();
        applyStimulus(1'b0, 8'h00, 16'h0000);
        if (LAT > 1) stepClock();
        checkOutput("final_valid", v2c_valid_o, 1);
        checkOutput("final_msg", v2c_msg_vec_o, expMsg[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
